// File: rtl/booth_mul_seq_if.sv
// Purpose: request/response bundle between the FP multiplier controller and booth_mul_seq.
// Latency: n/a (wiring only).
// Backpressure: level request (Data_valid) answered by a one-cycle Ack; no other flow control.
//
// Signals:
//   Datain1, Datain2 : unsigned mantissa operands (hidden bit included)
//   Data_valid       : level request, held by the caller until it samples Ack
//   Dataout          : registered 2*WIDTH-bit product, valid with Ack and held afterwards
//   Ack              : one-cycle completion pulse
//   Busy             : multiplier is not idle
// Modports: master = caller side, slave = multiplier side.

interface booth_mul_seq_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   Datain1;
    logic [WIDTH-1:0]   Datain2;
    logic               Data_valid;
    logic [2*WIDTH-1:0] Dataout;
    logic               Ack;
    logic               Busy;

    modport master (
        output Datain1,
        output Datain2,
        output Data_valid,
        input  Dataout,
        input  Ack,
        input  Busy
    );

    modport slave (
        input  Datain1,
        input  Datain2,
        input  Data_valid,
        output Dataout,
        output Ack,
        output Busy
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Purpose: sequential radix-2 Booth multiplier for unsigned WIDTH-bit mantissas, 2*WIDTH-bit product.
// Latency: accept edge T -> Ack during cycle T+WIDTH+2; zero operand -> Ack during cycle T+1.
// Backpressure: one request at a time; a request still high after Ack parks in HOLD until it drops.
//
// Ports:
//   CLK  : clock, rising edge
//   RSTn : asynchronous active-low reset, clears all state and outputs immediately
//   bus  : booth_mul_seq_if.slave (operands, Data_valid in; Dataout, Ack, Busy out)

module booth_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RSTn,
    booth_mul_seq_if.slave   bus
);

    // Operands carry one extra zero MSB so signed Booth recoding yields the
    // unsigned product; the accumulator carries one more bit again so that
    // A +/- M never overflows.
    localparam int QW = WIDTH + 1;
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [QW-1:0]      m;
    logic [QW-1:0]      m_nxt;
    logic [QW-1:0]      q;
    logic [QW-1:0]      q_nxt;
    logic               qm1;
    logic               qm1_nxt;
    logic [AW-1:0]      a;
    logic [AW-1:0]      a_nxt;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic [2*WIDTH-1:0] dout;
    logic [2*WIDTH-1:0] dout_nxt;
    logic               ack;
    logic               ack_nxt;

    // One Booth step worth of datapath, evaluated every cycle and only
    // committed while in RUN.
    logic [AW-1:0]      m_ext;
    logic [AW-1:0]      a_sum;
    logic [AW-1:0]      a_shr;
    logic [QW-1:0]      q_shr;
    logic               last_step;
    logic               zero_op;

    always_comb begin
        m_ext = {m[QW-1], m};
        a_sum = a;
        case ({q[0], qm1})
            2'b01:   a_sum = a + m_ext;
            2'b10:   a_sum = a - m_ext;
            default: a_sum = a;
        endcase
        // Arithmetic right shift of {A, Q, Q_-1}: A's MSB is replicated,
        // A's LSB falls into Q, and Q's LSB becomes the new Q_-1.
        a_shr = {a_sum[AW-1], a_sum[AW-1:1]};
        q_shr = {a_sum[0], q[QW-1:1]};
    end

    assign last_step = (cnt == CW'(WIDTH));
    assign zero_op   = (bus.Datain1 == '0) || (bus.Datain2 == '0);

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state;
        m_nxt     = m;
        q_nxt     = q;
        qm1_nxt   = qm1;
        a_nxt     = a;
        cnt_nxt   = cnt;
        dout_nxt  = dout;
        ack_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.Data_valid) begin
                    m_nxt   = {1'b0, bus.Datain1};
                    q_nxt   = {1'b0, bus.Datain2};
                    qm1_nxt = 1'b0;
                    a_nxt   = '0;
                    cnt_nxt = '0;
                    if (zero_op) begin
                        // Product is trivially zero: skip the iterations.
                        dout_nxt  = '0;
                        ack_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end

            RUN: begin
                a_nxt   = a_shr;
                q_nxt   = q_shr;
                qm1_nxt = q[0];
                cnt_nxt = cnt + CW'(1);
                if (last_step) begin
                    // Product is non-negative and fits in the low 2*WIDTH
                    // bits of {A, Q} after the final shift.
                    dout_nxt  = {a_shr[WIDTH-2:0], q_shr};
                    ack_nxt   = 1'b1;
                    state_nxt = DONE;
                end
            end

            DONE: begin
                // A caller that has not yet dropped its request must not be
                // accepted again, so park in HOLD until it does.
                state_nxt = bus.Data_valid ? HOLD : IDLE;
            end

            HOLD: begin
                if (!bus.Data_valid) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m    <= '0;
            q    <= '0;
            qm1  <= 1'b0;
            a    <= '0;
            cnt  <= '0;
            dout <= '0;
            ack  <= 1'b0;
        end else begin
            m    <= m_nxt;
            q    <= q_nxt;
            qm1  <= qm1_nxt;
            a    <= a_nxt;
            cnt  <= cnt_nxt;
            dout <= dout_nxt;
            ack  <= ack_nxt;
        end
    end

    assign bus.Dataout = dout;
    assign bus.Ack     = ack;
    assign bus.Busy    = (state != IDLE);

    // Ack is only ever raised on entry to DONE, and DONE never repeats.
    ack_in_done_a: assert property (
        @(posedge CLK) disable iff (!RSTn) ack |-> (state == DONE)
    );

    ack_single_a: assert property (
        @(posedge CLK) disable iff (!RSTn) ack |=> !ack
    );

    cnt_bound_a: assert property (
        @(posedge CLK) disable iff (!RSTn) (state == RUN) |-> (cnt <= CW'(WIDTH))
    );

endmodule

// File: tb/tb_booth_mul_seq.sv
module tb_booth_mul_seq;

    localparam int W   = 8;
    localparam int LAT = W + 1;   // posedges from accept edge to the edge raising Ack

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;

    booth_mul_seq_if #(.WIDTH(W)) bus ();

    booth_mul_seq #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2*W-1:0] dout;
        int             lat;
        int             acc;
        int             id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every Ack must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RSTn && bus.Ack === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ack: Ack=1 with no request outstanding (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("dout_req%0d", mon_e.id), 32'(bus.Dataout), 32'(mon_e.dout));
                check($sformatf("latency_req%0d", mon_e.id), 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns just after the accept edge.
    task automatic start_req(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2*W-1:0] exp, input int lat,
                             input int id, input bit push);
        exp_t n;
        bus.Datain1    = a;
        bus.Datain2    = b;
        bus.Data_valid = 1'b1;
        n.dout = exp;
        n.lat  = lat;
        n.acc  = cyc + 1;
        n.id   = id;
        if (push) sb.push_back(n);
        @(posedge CLK);
    endtask

    task automatic wait_ack(input int id, input bit scramble);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (bus.Ack === 1'b1) begin
                seen = 1'b1;
            end else if (scramble) begin
                bus.Datain1 = W'($urandom);
                bus.Datain2 = W'($urandom);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout_req%0d: no Ack within 40 cycles", id);
        end
    endtask

    task automatic wait_idle(input int id);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 10 && !idle; i++) begin
            @(negedge CLK);
            if (bus.Busy === 1'b0) idle = 1'b1;
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout_req%0d: Busy still high after 10 cycles", id);
        end
    endtask

    // Called at the negedge where Ack was seen; keeps valid high for `hold`
    // more cycles (no second Ack allowed), then drops it.
    task automatic finish_req(input int id, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            check($sformatf("hold_no_ack_req%0d", id), 32'(bus.Ack), 32'd0);
            check($sformatf("hold_busy_req%0d", id), 32'(bus.Busy), 32'd1);
        end
        bus.Data_valid = 1'b0;
        wait_idle(id);
    endtask

    // Directed vectors: operands, hand-computed product, latency, drop-valid-during-RUN flag.
    logic [W-1:0]   va   [6] = '{8'hFF, 8'h00, 8'hC0, 8'hB3, 8'h35, 8'h01};
    logic [W-1:0]   vb   [6] = '{8'hFF, 8'h9A, 8'hA0, 8'h00, 8'h80, 8'hFF};
    logic [2*W-1:0] vexp [6] = '{16'hFE01, 16'h0000, 16'h7800, 16'h0000, 16'h1A80, 16'h00FF};
    int             vlat [6] = '{LAT, 0, LAT, 0, LAT, LAT};
    bit             vdrop[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        bus.Datain1    = '0;
        bus.Datain2    = '0;
        bus.Data_valid = 1'b0;

        // Reset state
        #12;
        check("rst_dout", 32'(bus.Dataout), 32'd0);
        check("rst_ack",  32'(bus.Ack),     32'd0);
        check("rst_busy", 32'(bus.Busy),    32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);

        // 0x80 x 0x80, held until Ack, Ack exactly one cycle
        start_req(8'h80, 8'h80, 16'h4000, LAT, 1, 1'b1);
        #1;
        check("t1_busy_after_accept", 32'(bus.Busy), 32'd1);
        wait_ack(1, 1'b0);
        check("t1_busy_in_done", 32'(bus.Busy), 32'd1);
        finish_req(1, 1);

        // Corner products, zero fast path, valid dropped during RUN
        for (int k = 0; k < 6; k++) begin
            start_req(va[k], vb[k], vexp[k], vlat[k], 10 + k, 1'b1);
            if (vdrop[k]) begin
                repeat (3) @(negedge CLK);
                bus.Data_valid = 1'b0;
                wait_ack(10 + k, 1'b0);
                @(negedge CLK);
                check($sformatf("drop_idle_after_done_req%0d", 10 + k), 32'(bus.Busy), 32'd0);
            end else begin
                wait_ack(10 + k, 1'b0);
                finish_req(10 + k, 1);
            end
        end

        // Valid held 5 cycles after Ack, low 1 cycle, then a new request
        start_req(8'h12, 8'h34, 16'h03A8, LAT, 20, 1'b1);
        wait_ack(20, 1'b0);
        finish_req(20, 5);
        start_req(8'h90, 8'h90, 16'h5100, LAT, 21, 1'b1);
        wait_ack(21, 1'b0);
        finish_req(21, 1);

        // Reset in the middle of RUN abandons the request
        start_req(8'hFF, 8'hFF, 16'hFE01, LAT, 30, 1'b0);
        repeat (4) @(posedge CLK);
        #2;
        RSTn = 1'b0;
        #1;
        check("midrst_ack",  32'(bus.Ack),     32'd0);
        check("midrst_dout", 32'(bus.Dataout), 32'd0);
        check("midrst_busy", 32'(bus.Busy),    32'd0);
        bus.Data_valid = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (12) @(negedge CLK);
        start_req(8'h80, 8'hC0, 16'h6000, LAT, 31, 1'b1);
        wait_ack(31, 1'b0);
        finish_req(31, 1);

        // Operand inputs scrambled during RUN
        start_req(8'hAA, 8'h55, 16'h3872, LAT, 40, 1'b1);
        wait_ack(40, 1'b1);
        finish_req(40, 1);

        repeat (3) @(negedge CLK);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Sequential radix-2 Booth mantissa multiplier, the callee directly downstream of the 16-bit FP multiplier controller.
- Accepts two unsigned WIDTH-bit mantissas (hidden bit included) under a level valid / pulsed ack handshake.
- Returns the 2*WIDTH-bit unsigned product.
- Operands are internally zero-extended by one bit so signed Booth recoding yields the unsigned product.

Parameters:
WIDTH, 8, operand width in bits; product width is 2*WIDTH; iteration count is WIDTH+1

Ports:
CLK  input  1  clock, rising edge
RSTn  input  1  reset, asynchronous, active-low
Datain1  input  WIDTH  multiplicand mantissa (unsigned)
Datain2  input  WIDTH  multiplier mantissa (unsigned)
Data_valid  input  1  level request; caller holds high until it samples Ack
Dataout  output  2*WIDTH  product, registered; valid when Ack=1 and held until the next completion
Ack  output  1  registered one-cycle completion pulse
Busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (RSTn=0, asynchronous, effective immediately):
  - Dataout=0, Ack=0, Busy=0, state=IDLE, counter=0.
  - All datapath registers are cleared.
- States: IDLE, RUN, DONE, HOLD.
- IDLE:
  - Ack=0.
  - On Data_valid=1 at edge T: latch M={0,Datain1} (WIDTH+1 bits), Q={0,Datain2}, Q_-1=0, A=0 (WIDTH+2 bits), count=0.
  - Go to RUN.
  - Zero fast path: if Datain1==0 or Datain2==0 at edge T, load Dataout=0 and go directly to DONE. Ack is high in cycle T+1.
- RUN, one Booth step per cycle:
  - {Q[0],Q_-1}=01: A=A+sign-extended M.
  - {Q[0],Q_-1}=10: A=A-sign-extended M.
  - 00 or 11: no add.
  - Then arithmetic right shift of {A,Q,Q_-1} by 1 (A MSB replicated).
  - count increments each cycle.
  - After step WIDTH+1 (count==WIDTH), Dataout loads {A,Q}[2*WIDTH-1:0] and the state goes to DONE.
- Latency: Data_valid sampled at edge T → Ack=1 during cycle T+WIDTH+2 (T+10 for WIDTH=8). The zero fast path gives T+1.
- DONE:
  - Ack=1 for exactly this cycle; Dataout is stable.
  - Next state: IDLE if Data_valid=0, else HOLD.
- HOLD:
  - Ack=0.
  - Stays until Data_valid=0, then goes to IDLE.
  - Guarantees one request yields exactly one Ack, even though the caller deasserts valid one cycle after seeing Ack.
- Datain1/Datain2 changes after the latch edge are ignored until the next IDLE acceptance.
- Data_valid dropping during RUN: the operation still completes and Ack still pulses once; DONE then returns to IDLE.
- Dataout is unchanged outside the completion load. It is never driven with partial results.
- Arithmetic widths: A is WIDTH+2 bits, so intermediate add/sub cannot overflow. The final product of unsigned operands is non-negative and fits 2*WIDTH bits.
- Reset asserted mid-RUN: the operation is abandoned and all outputs are cleared immediately. No Ack is produced for the abandoned request.

Test Plan:
1. Datain1=0x80, Datain2=0x80, valid held until Ack → Dataout=0x4000, Ack high exactly 1 cycle, 10 cycles after the accept edge; Busy high from T+1 until return to IDLE.
2. Exhaustive-corner products:
   - 0xFF×0xFF → 0xFE01
   - 0xC0×0xA0 → 0x7800
   - 0x35×0x80 → 0x1A80
   - 0x01×0xFF → 0x00FF
3. 0x00×0x9A and 0xB3×0x00 → Dataout=0x0000, Ack at T+1; previous nonzero Dataout is overwritten.
4. Valid held high 5 cycles after Ack → no second Ack, state stays HOLD; valid low for 1 cycle, then 0x90×0x90 → one new Ack, Dataout=0x5100.
5. RSTn pulsed low at RUN step 4 of 0xFF×0xFF → Ack=0, Dataout=0, Busy=0 asynchronously, with no Ack afterward; next request 0x80×0xC0 → 0x6000 with normal latency.
6. Datain1/Datain2 toggled randomly during RUN of 0xAA×0x55 → Dataout=0x3872, unaffected.
